// File: rtl/fifomn_port_scheduler.sv
// rtl/fifomn_port_scheduler.sv - round-robin push-lane scheduler, pop gating and flush sequencer for a multi-port FIFO
module fifomn_port_scheduler #(
    parameter int DATA_WIDTH = 4,
    parameter int ENTRIES    = 8,
    parameter int ADDR_SIZE  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1,
    parameter int NUM_WR     = 2,
    parameter int NUM_RD     = 2,
    parameter int NUM_REQ    = 4,
    parameter int RRW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NUM_REQ-1:0]           i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]           o_req_ready,
    input  logic [NUM_RD-1:0]            i_pop_req,
    output logic [NUM_RD-1:0]            o_pop_ack,
    input  logic [ADDR_SIZE:0]           i_fifo_cnt,
    output logic [NUM_WR-1:0]            o_fifo_psh,
    output logic [NUM_WR*DATA_WIDTH-1:0] o_fifo_data,
    output logic [NUM_RD-1:0]            o_fifo_pop,
    output logic [ENTRIES-1:0]           o_fifo_clear,
    input  logic                         i_flush,
    output logic                         o_flush_done,
    output logic                         o_busy,
    output logic [RRW-1:0]               o_rr_ptr
);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, DONE} state_t;

    state_t         state;
    logic [RRW-1:0] rr_ptr;
    logic [RRW-1:0] rr_next;
    logic           idle;
    logic           any_grant;
    logic           pop_run;
    int             free_slots;
    int             limit;
    int             last_off;
    int             last_req;
    int             offset [NUM_REQ];
    int             rank   [NUM_REQ];

    // Gating with reset keeps every output at 0 while reset is held, even with live inputs.
    assign idle = i_reset_n && (state == IDLE);

    // A producer's rank is the number of valid producers ahead of it in the rotated scan;
    // rank doubles as its push lane, which keeps lanes contiguous from 0.
    always_comb begin
        free_slots = (int'(i_fifo_cnt) > ENTRIES) ? 0 : ENTRIES - int'(i_fifo_cnt);
        limit      = (free_slots < NUM_WR) ? free_slots : NUM_WR;
        for (int r = 0; r < NUM_REQ; r++) begin
            offset[r] = (r + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            rank[r] = 0;
            for (int q = 0; q < NUM_REQ; q++) begin
                if (i_req_valid[q] && (offset[q] < offset[r])) rank[r] = rank[r] + 1;
            end
        end
        o_req_ready = '0;
        any_grant   = 1'b0;
        last_off    = -1;
        last_req    = 0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (idle && i_req_valid[r] && (rank[r] < limit)) begin
                o_req_ready[r] = 1'b1;
                any_grant      = 1'b1;
                if (offset[r] > last_off) begin
                    last_off = offset[r];
                    last_req = r;
                end
            end
        end
        o_fifo_psh  = '0;
        o_fifo_data = '0;
        for (int l = 0; l < NUM_WR; l++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (o_req_ready[r] && (rank[r] == l)) begin
                    o_fifo_psh[l]                           = 1'b1;
                    o_fifo_data[l*DATA_WIDTH +: DATA_WIDTH] = i_req_data[r*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        rr_next = RRW'((last_req + 1) % NUM_REQ);
    end

    // Pops are only issued as a contiguous prefix backed by entries already in the FIFO.
    always_comb begin
        pop_run   = idle;
        o_pop_ack = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            pop_run      = pop_run && i_pop_req[i] && (i < int'(i_fifo_cnt));
            o_pop_ack[i] = pop_run;
        end
    end

    assign o_fifo_pop   = o_pop_ack;
    assign o_fifo_clear = {ENTRIES{state == CLEAR}};
    assign o_flush_done = (state == DONE);
    assign o_busy       = (state != IDLE);
    assign o_rr_ptr     = rr_ptr;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_grant) rr_ptr <= rr_next;
                    if (i_flush)   state  <= DRAIN;
                end
                DRAIN:   state <= CLEAR;
                CLEAR:   state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifomn_port_scheduler.sv
// tb/tb_fifomn_port_scheduler.sv - randomized self-checking bench for fifomn_port_scheduler
module tb_fifomn_port_scheduler;

    localparam int DW      = 4;
    localparam int ENTRIES = 8;
    localparam int AS      = 3;
    localparam int NUM_WR  = 2;
    localparam int NUM_RD  = 2;
    localparam int NUM_REQ = 4;
    localparam int RRW     = 2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*DW-1:0]   req_data = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_RD-1:0]       pop_req = '0;
    logic [NUM_RD-1:0]       pop_ack;
    logic [AS:0]             fifo_cnt = '0;
    logic [NUM_WR-1:0]       fifo_psh;
    logic [NUM_WR*DW-1:0]    fifo_data;
    logic [NUM_RD-1:0]       fifo_pop;
    logic [ENTRIES-1:0]      fifo_clear;
    logic                    flush = 1'b0;
    logic                    flush_done;
    logic                    busy;
    logic [RRW-1:0]          rr_ptr;

    int n_checks = 0;
    int n_errors = 0;
    int m_state  = 0;   // 0 idle, 1 drain, 2 clear, 3 done
    int m_rr     = 0;

    fifomn_port_scheduler #(
        .DATA_WIDTH(DW), .ENTRIES(ENTRIES), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD), .NUM_REQ(NUM_REQ)
    ) dut (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_req_valid(req_valid), .i_req_data(req_data), .o_req_ready(req_ready),
        .i_pop_req(pop_req), .o_pop_ack(pop_ack), .i_fifo_cnt(fifo_cnt),
        .o_fifo_psh(fifo_psh), .o_fifo_data(fifo_data), .o_fifo_pop(fifo_pop),
        .o_fifo_clear(fifo_clear), .i_flush(flush), .o_flush_done(flush_done),
        .o_busy(busy), .o_rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: compare all outputs with the reference at mid-cycle, then advance the reference.
    task automatic cycle();
        logic [NUM_REQ-1:0]   e_ready;
        logic [NUM_WR-1:0]    e_psh;
        logic [NUM_WR*DW-1:0] e_data;
        logic [NUM_RD-1:0]    e_pop;
        int free, lim, n, last, r, cnt;
        bit run;
        @(negedge clk);
        #1;
        e_ready = '0; e_psh = '0; e_data = '0; e_pop = '0;
        n = 0; last = -1;
        cnt  = int'(fifo_cnt);
        free = (cnt > ENTRIES) ? 0 : ENTRIES - cnt;
        lim  = (free < NUM_WR) ? free : NUM_WR;
        if (m_state == 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                r = (m_rr + k) % NUM_REQ;
                if (req_valid[r] && n < lim) begin
                    e_ready[r] = 1'b1;
                    e_psh[n] = 1'b1;
                    e_data[n*DW +: DW] = req_data[r*DW +: DW];
                    n++;
                    last = r;
                end
            end
        end
        run = (m_state == 0);
        for (int i = 0; i < NUM_RD; i++) begin
            run = run && pop_req[i] && (i < cnt);
            e_pop[i] = run;
        end
        check("ready", 32'(req_ready), 32'(e_ready));
        check("psh",   32'(fifo_psh),  32'(e_psh));
        check("data",  32'(fifo_data), 32'(e_data));
        check("pop_ack", 32'(pop_ack), 32'(e_pop));
        check("fifo_pop", 32'(fifo_pop), 32'(e_pop));
        check("clear", 32'(fifo_clear), (m_state == 2) ? 32'hFF : 32'h0);
        check("done",  32'(flush_done), 32'(m_state == 3));
        check("busy",  32'(busy), 32'(m_state != 0));
        check("rr",    32'(rr_ptr), 32'(m_rr));
        @(posedge clk);
        if (m_state == 0) begin
            if (n > 0) m_rr = (last + 1) % NUM_REQ;
            if (flush) m_state = 1;
        end else begin
            m_state = (m_state + 1) % 4;
        end
        #1;
    endtask

    // Asynchronous reset inside a cycle; outputs must drop before any clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_psh",   32'(fifo_psh), 32'h0);
        check("rst_pop",   32'(pop_ack), 32'h0);
        check("rst_clear", 32'(fifo_clear), 32'h0);
        check("rst_done",  32'(flush_done), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_rr",    32'(rr_ptr), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_state = 0;
        m_rr    = 0;
    endtask

    initial begin
        req_data = {4'hD, 4'hC, 4'hB, 4'hA};
        @(posedge clk);
        #1;
        req_valid = '1; pop_req = '1; fifo_cnt = 4'd3;
        do_reset();

        // round-robin pairs from rr=0
        req_valid = 4'b1111; pop_req = '0; fifo_cnt = 0;
        cycle();
        check("t1_rr2", 32'(rr_ptr), 32'd2);
        check("t1_ready2", 32'(req_ready), 32'b1100);
        check("t1_data2", 32'(fifo_data), 32'hDC);
        cycle();
        check("t1_rr0", 32'(rr_ptr), 32'd0);

        // wrap from rr=3
        do_reset();
        req_valid = 4'b0100;
        cycle();
        check("t2_rr3", 32'(rr_ptr), 32'd3);
        req_valid = 4'b1001;
        cycle();
        check("t2_rr1", 32'(rr_ptr), 32'd1);

        // one free slot, then full
        do_reset();
        req_valid = 4'b1111; fifo_cnt = 4'd7;
        cycle();
        check("t3_rr1", 32'(rr_ptr), 32'd1);
        fifo_cnt = 4'd8;
        cycle();
        check("t3_full_psh", 32'(fifo_psh), 32'h0);
        check("t3_full_rr", 32'(rr_ptr), 32'd1);

        // pop gating
        req_valid = '0;
        fifo_cnt = 4'd1; pop_req = 2'b11;
        cycle();
        check("t4_ack01", 32'(pop_ack), 32'b01);
        fifo_cnt = 4'd0; pop_req = 2'b01;
        cycle();
        fifo_cnt = 4'd5; pop_req = 2'b10;
        cycle();
        check("t4_gap", 32'(pop_ack), 32'b00);

        // flush sequence with all producers valid
        req_valid = '1; fifo_cnt = 4'd2; pop_req = 2'b11; flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int i = 0; i < 5; i++) cycle();

        // reset while in CLEAR
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        cycle();
        check("t6_in_clear", 32'(fifo_clear), 32'hFF);
        do_reset();
        for (int i = 0; i < 3; i++) cycle();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid = NUM_REQ'($urandom);
            req_data  = (NUM_REQ*DW)'($urandom);
            pop_req   = NUM_RD'($urandom);
            fifo_cnt  = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(ENTRIES + 1, 15))
                                                    : 4'($urandom_range(0, ENTRIES));
            flush     = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else cycle();
        end
        flush = 1'b1;
        for (int i = 0; i < 10; i++) cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
